// File: rtl/irq_arbiter.sv
// irq_arbiter: per-source event FIFOs feeding a round-robin, one-at-a-time interrupt issuer.
// Optional ack timeout (and timeout_err port) enabled by defining IRQ_ARB_TIMEOUT_EN.

module irq_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         drop
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != '0);
    // a pop on the same edge frees a slot, so a full FIFO still accepts the push
    do_push  = push && ((cnt_q != FULL_CNT) || do_pop);
    drop     = push && !do_push;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
endmodule

module irq_arbiter #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [31:0] key_data,
  input  logic        eth_valid,
  input  logic [31:0] eth_data,
  output logic        irq_key,
  output logic        irq_eth,
  output logic [31:0] irq_data,
  input  logic        irq_ack,
  output logic        ovf_key,
  output logic        ovf_eth,
  input  logic        ovf_clr,
  output logic        busy
`ifdef IRQ_ARB_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);
  localparam int NUM_SRC = 2;
  localparam int SRC_KEY = 0;
  localparam int SRC_ETH = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  logic [NUM_SRC-1:0]       src_vld, pop, empty, drop, req, grant;
  logic [NUM_SRC-1:0][31:0] src_data, head;
  logic [31:0]              grant_data;
  logic [NUM_SRC-1:0]       irq_q, ovf_q, ovf_d;
  logic [31:0]              irq_data_q;
  logic                     last_grant_q;  // 1 = Ethernet granted last
  logic                     tmo_fire;
  state_t                   state_q;

  assign src_vld  = {eth_valid, key_valid};
  assign src_data = {eth_data, key_data};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_arb_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk      (sys_clk),
      .rst_n    (rst_n),
      .push     (src_vld[g]),
      .push_data(src_data[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .empty    (empty[g]),
      .drop     (drop[g])
    );
  end

  always_comb begin
    req = ~empty;
    if (&req) grant = last_grant_q ? (NUM_SRC'(1) << SRC_KEY) : (NUM_SRC'(1) << SRC_ETH);
    else      grant = req;
    pop        = (state_q == IDLE) ? grant : '0;
    grant_data = grant[SRC_ETH] ? head[SRC_ETH] : head[SRC_KEY];
  end

`ifdef IRQ_ARB_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_err_q;

  assign tmo_fire = (state_q == WAIT_ACK) && !irq_ack && (tmo_cnt_q == TMO_LAST);

  // held at zero outside WAIT_ACK, so every ISSUE starts a fresh count
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == WAIT_ACK) ? tmo_cnt_q + TW'(1) : '0;
      tmo_err_q <= tmo_fire | (tmo_err_q & ~ovf_clr);
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      irq_data_q   <= '0;
      last_grant_q <= 1'b0;
    end else begin
      irq_q <= '0;
      unique case (state_q)
        IDLE: if (|grant) begin
          state_q      <= ISSUE;
          irq_q        <= grant;
          irq_data_q   <= grant_data;
          last_grant_q <= grant[SRC_ETH];
        end
        ISSUE:    state_q <= irq_ack ? IDLE : WAIT_ACK;
        WAIT_ACK: if (irq_ack || tmo_fire) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // a new drop on the same edge as ovf_clr keeps the flag set
  assign ovf_d = drop | (ovf_q & {NUM_SRC{~ovf_clr}});

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign irq_key  = irq_q[SRC_KEY];
  assign irq_eth  = irq_q[SRC_ETH];
  assign irq_data = irq_data_q;
  assign ovf_key  = ovf_q[SRC_KEY];
  assign ovf_eth  = ovf_q[SRC_ETH];
  assign busy     = (state_q != IDLE);
endmodule
